// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - ready/valid pipeline stage with 2-entry skid buffer, flush and perf counters
// in_ready is registered so downstream back-pressure never reaches upstream combinationally.
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 10,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_ready_q;
  logic [CNT_W-1:0]    bubble_cnt_q, flush_cnt_q;
  logic                accept, consume;

  assign out_valid  = (state_q != EMPTY);
  assign in_ready   = in_ready_q;
  assign accept     = in_valid & in_ready_q;
  assign consume    = out_valid & out_ready;
  assign out_data   = main_data_q;
  assign out_ctrl   = main_ctrl_q;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = CTRL_NOP;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_NOP;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (consume) begin
            main_data_d = '0;
            main_ctrl_d = CTRL_NOP;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so the only possible movement is skid -> main
          if (consume) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = CTRL_NOP;
            state_d     = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (out_ready && !out_valid && bubble_cnt_q != CNT_MAX)
        bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      if (flush && state_q != EMPTY && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP ({CTRL_W{1'b0}}),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    reset = 1'b0;

    // first beat latency and streaming
    out_ready = 1'b1;
    drive(1'b1, 32'h1000_0004, 10'h3FF);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 32'h1000_0004);
    check("lat_ctrl", out_ctrl, 10'h3FF);
    check("lat_occ", occupancy, 1);
    drive(1'b1, 32'h0000_00B0, 10'h001);
    tick();
    check("stream_b", out_data, 32'h0000_00B0);
    check("stream_b_ctrl", out_ctrl, 10'h001);
    drive(1'b1, 32'h0000_00C0, 10'h002);
    tick();
    check("stream_c", out_data, 32'h0000_00C0);
    check("stream_occ", occupancy, 1);
    drive(1'b0, '0, '0);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl", out_ctrl, 0);
    check("stream_bubble", bubble_cnt, 1);

    // stall fills the skid slot, then drains in order
    do_reset();
    drive(1'b1, 32'hA, 10'h00A);
    tick();
    drive(1'b1, 32'hB, 10'h00B);
    tick();
    check("stall_occ", occupancy, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_data_a", out_data, 32'hA);
    drive(1'b1, 32'hC, 10'h00C);
    tick();
    check("stall_hold_occ", occupancy, 2);
    check("stall_hold_data", out_data, 32'hA);
    check("stall_hold_ctrl", out_ctrl, 10'h00A);
    out_ready = 1'b1;
    tick();
    check("drain_b", out_data, 32'hB);
    check("drain_b_occ", occupancy, 1);
    check("drain_b_in_ready", in_ready, 1);
    tick();
    check("drain_c", out_data, 32'hC);
    check("drain_c_ctrl", out_ctrl, 10'h00C);
    drive(1'b0, '0, '0);
    tick();
    check("stall_empty", out_valid, 0);
    check("stall_bubble", bubble_cnt, 0);

    // flush while full, with a beat presented on the same cycle
    do_reset();
    drive(1'b1, 32'hA, 10'h00A);
    tick();
    drive(1'b1, 32'hB, 10'h00B);
    tick();
    drive(1'b1, 32'hD, 10'h00D);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_data", out_data, 0);
    check("flush_occ", occupancy, 0);
    check("flush_cnt", flush_cnt, 1);
    check("flush_in_ready", in_ready, 1);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("flush_no_d", out_valid, 0);
    drive(1'b1, 32'hE, 10'h00E);
    tick();
    check("post_flush_e", out_data, 32'hE);
    drive(1'b0, '0, '0);
    tick();
    check("post_flush_skid_clear", out_valid, 0);

    // flush while empty is not counted, but bubbles are
    do_reset();
    out_ready = 1'b1;
    flush = 1'b1;
    repeat (3) tick();
    flush = 1'b0;
    check("empty_flush_cnt", flush_cnt, 0);
    check("empty_flush_bubble", bubble_cnt, 3);

    // bubble counter saturation
    do_reset();
    out_ready = 1'b1;
    repeat (14) tick();
    check("bubble_14", bubble_cnt, 14);
    repeat (6) tick();
    check("bubble_sat", bubble_cnt, 4'hF);
    repeat (2) tick();
    check("bubble_sat_hold", bubble_cnt, 4'hF);

    // asynchronous reset while full
    do_reset();
    drive(1'b1, 32'hA, 10'h00A);
    tick();
    drive(1'b1, 32'hB, 10'h00B);
    tick();
    check("pre_async_occ", occupancy, 2);
    #3;
    reset = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_occ", occupancy, 0);
    check("async_data", out_data, 0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hF0, 10'h0F0);
    tick();
    check("async_after_valid", out_valid, 1);
    check("async_after_data", out_data, 32'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
